// File: rtl/out_rx.sv
// out_rx: toggle-handshake byte receiver feeding a small FIFO with a
// valid/ready read port, plus sticky overflow and end-of-transmission flags.
// Optional feature: define OUT_RX_EOT_EN to enable the EOT_BYTE detector on
// the done output. With the macro undefined, done is tied low.
module out_rx #(
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] EOT_BYTE    = 8'h04
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_dat,
    input  logic                     in_ctl,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [7:0]               m_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     done
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_LV = (AW+1)'(DEPTH);
    localparam logic [AW:0]    LV_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   strobe;
    logic [7:0]             mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            cnt;
    logic                   full;
    logic                   pop;
    logic                   push;

    // Synchronize the sender toggle and keep one history flop for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_ctl};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Any level change seen at the synchronizer output is one new byte
    always_comb begin
        strobe = sync_q[SYNC_STAGES-1] ^ hist_q;
        full   = (cnt == FULL_LV);
        pop    = m_valid & m_ready;
        // A full FIFO still accepts the byte when the head leaves on the same edge
        push   = strobe & (~full | pop);
    end

    // FIFO storage holds data only, so it carries no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push/pop balance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + LV_ONE;
                2'b01:   cnt <= cnt - LV_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky drop indicator: strobe arrived with no room and no pop to make room
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (strobe && full && !pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef OUT_RX_EOT_EN
    // Sticky end-of-transmission: set even when the EOT byte itself is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else if (strobe && (in_dat == EOT_BYTE)) begin
            done <= 1'b1;
        end
    end
`else
    assign done = 1'b0;
`endif

    // Read port is driven purely from registered occupancy and head pointer
    always_comb begin
        level   = cnt;
        m_valid = (cnt != '0);
        m_data  = m_valid ? mem[rd_ptr] : 8'h00;
    end

endmodule
